// File: rtl/tl_ul_link_buffer.sv
// TL-UL link buffer: registered A/D channel FIFOs with a cap on outstanding A requests.
// Every output is driven from flops only; there is no input-to-output combinational path.

module tl_ul_link_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  input  logic             deq,
  output logic             not_empty,
  output logic [WIDTH-1:0] out_bits
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             enq;

  // Full means not ready, even if a dequeue happens this cycle: no bypass path.
  assign in_ready  = (count != (AW+1)'(DEPTH));
  assign enq       = in_valid & in_ready;
  assign not_empty = (count != '0);
  assign out_bits  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= in_bits;
        wr_ptr      <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module tl_ul_link_buffer #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_a_valid,
  output logic        in_a_ready,
  input  logic [78:0] in_a_bits,
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [78:0] out_a_bits,
  input  logic        in_d_valid,
  output logic        in_d_ready,
  input  logic [43:0] in_d_bits,
  output logic        out_d_valid,
  input  logic        out_d_ready,
  output logic [43:0] out_d_bits,
  output logic [3:0]  inflight
);
  logic a_not_empty;
  logic a_fire;
  logic d_in_fire;
  logic d_out_fire;

  assign out_a_valid = a_not_empty && (inflight != 4'(MAX_INFLIGHT));
  assign a_fire      = out_a_valid & out_a_ready;
  assign d_in_fire   = in_d_valid & in_d_ready;
  assign d_out_fire  = out_d_valid & out_d_ready;

  tl_ul_link_fifo #(.WIDTH(79), .DEPTH(DEPTH)) a_fifo (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_a_valid),
    .in_ready (in_a_ready),
    .in_bits  (in_a_bits),
    .deq      (a_fire),
    .not_empty(a_not_empty),
    .out_bits (out_a_bits)
  );

  tl_ul_link_fifo #(.WIDTH(44), .DEPTH(DEPTH)) d_fifo (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_d_valid),
    .in_ready (in_d_ready),
    .in_bits  (in_d_bits),
    .deq      (d_out_fire),
    .not_empty(out_d_valid),
    .out_bits (out_d_bits)
  );

  // A D beat with nothing outstanding is a protocol error; the counter holds at 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
    end else if (a_fire && !d_in_fire) begin
      inflight <= inflight + 1'b1;
    end else if (!a_fire && d_in_fire && (inflight != '0)) begin
      inflight <= inflight - 1'b1;
    end
  end
endmodule
